// File: rtl/soml_qam16_mapper.sv
// -----------------------------------------------------------------------------
// soml_qam16_mapper
//
// Transmit-side 16-QAM symbol mapper for the SOML link. Each accepted byte is
// split into two 4-bit symbols: the high nibble is sent first, then the low
// nibble. In each nibble the upper 2 bits select the I level and the lower 2
// bits select the Q level. Each 2-bit field is Gray-mapped onto the 4-PAM
// levels {-3,-1,+1,+3}, and each level is output as a signed fixed-point
// value (level << Q) that is N bits wide.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_valid  input byte valid
//   s_ready  mapper can accept s_data this cycle
//   s_data   payload byte; [7:4] = symbol 0, [3:0] = symbol 1
//   m_valid  output symbol valid
//   m_ready  downstream accepts the symbol
//   m_i      signed in-phase level (zero when m_valid=0)
//   m_q      signed quadrature level (zero when m_valid=0)
//   m_last   current symbol is the last of its frame
//   sym_cnt  index of the current symbol within its frame
//
// State table
//   state | meaning
//   IDLE  | no byte held; m_valid=0; ready for a new byte
//   HI    | byte held; emitting nibble [7:4]
//   LO    | byte held; emitting nibble [3:0]; a new byte may be taken on
//         | the same edge that this symbol is consumed
// -----------------------------------------------------------------------------
module soml_qam16_mapper #(
    parameter int N          = 16,
    parameter int Q          = 8,
    parameter int FRAME_SYMS = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [N-1:0]                  m_i,
    output logic [N-1:0]                  m_q,
    output logic                          m_last,
    output logic [$clog2(FRAME_SYMS)-1:0] sym_cnt
);

    localparam int CW = $clog2(FRAME_SYMS);

    // The integer part must be wide enough to hold +/-3 exactly.
    if (N - Q < 3) begin : g_bad_width
        $error("soml_qam16_mapper: N-Q must be >= 3");
    end
    if ((FRAME_SYMS < 2) || (FRAME_SYMS % 2 != 0)) begin : g_bad_frame
        $error("soml_qam16_mapper: FRAME_SYMS must be even and >= 2");
    end

    localparam logic [N-1:0] LVL_P1 = N'(1) << Q;
    localparam logic [N-1:0] LVL_P3 = N'(3) << Q;
    localparam logic [N-1:0] LVL_M1 = -LVL_P1;
    localparam logic [N-1:0] LVL_M3 = -LVL_P3;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  byte_q;
    logic [3:0]  nibble;
    logic        s_xfer;
    logic        m_xfer;

    // Gray order: adjacent levels differ in exactly one bit.
    function automatic logic [N-1:0] pam_level(input logic [1:0] bits);
        logic [N-1:0] lvl;
        case (bits)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

    // Every m_* output is decoded from registers only. The one combinational
    // path, m_ready -> s_ready, is what lets LO hand off to the next byte
    // without a bubble.
    assign m_valid = (state != IDLE);
    assign s_ready = (state == IDLE) | ((state == LO) & m_ready);
    assign s_xfer  = s_valid & s_ready;
    assign m_xfer  = m_valid & m_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_xfer) state_nxt = HI;
            HI:   if (m_xfer) state_nxt = LO;
            LO: begin
                if (m_xfer) state_nxt = s_xfer ? HI : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            byte_q  <= 8'h00;
            sym_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (s_xfer) begin
                byte_q <= s_data;
            end
            if (m_xfer) begin
                sym_cnt <= (sym_cnt == LAST_IDX) ? '0 : sym_cnt + 1'b1;
            end
        end
    end

    assign nibble = (state == HI) ? byte_q[7:4] : byte_q[3:0];
    assign m_i    = m_valid ? pam_level(nibble[3:2]) : '0;
    assign m_q    = m_valid ? pam_level(nibble[1:0]) : '0;
    assign m_last = m_valid & (sym_cnt == LAST_IDX);

endmodule

// File: tb/tb_soml_qam16_mapper.sv
// -----------------------------------------------------------------------------
// tb_soml_qam16_mapper
//
// Testbench for soml_qam16_mapper. The reference model is a queue of pending
// symbols: each accepted byte pushes two symbols onto the queue, and each
// output transfer pops one. The expected handshake signals are derived from
// the queue depth: valid when the queue is non-empty, and ready when the queue
// is empty, or when it holds one symbol and m_ready is high.
// -----------------------------------------------------------------------------
module tb_soml_qam16_mapper;

    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int FS = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = 8'h00;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [N-1:0]  m_i;
    logic [N-1:0]  m_q;
    logic          m_last;
    logic [5:0]    sym_cnt;

    soml_qam16_mapper #(.N(N), .Q(Q), .FRAME_SYMS(FS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_i     (m_i),
        .m_q     (m_q),
        .m_last  (m_last),
        .sym_cnt (sym_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [35:0] exp_q[$];   // {nibble, I, Q}
    int          xfers = 0;
    int          n_last = 0;
    bit          hit[16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [15:0] lvl(input logic [1:0] b);
        int l;
        case (b)
            2'b00:   l = -3;
            2'b01:   l = -1;
            2'b11:   l = 1;
            default: l = 3;
        endcase
        return 16'(l * (1 << Q));
    endfunction

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back({b[7:4], lvl(b[7:6]), lvl(b[5:4])});
        exp_q.push_back({b[3:0], lvl(b[3:2]), lvl(b[1:0])});
    endtask

    // Called at posedge+1; returns with time at the next posedge+1.
    task automatic step(input logic sv, input logic [7:0] sd, input logic mr, output logic acc);
        logic        ev, er, mx, lst;
        logic [35:0] f;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #4;
        ev  = (exp_q.size() != 0);
        er  = (exp_q.size() == 0) || ((exp_q.size() == 1) && mr);
        f   = ev ? exp_q[0] : 36'h0;
        lst = m_last;
        chk("m_valid", 32'(m_valid), 32'(ev));
        chk("s_ready", 32'(s_ready), 32'(er));
        if (ev) begin
            chk("m_i", 32'(m_i), 32'(f[31:16]));
            chk("m_q", 32'(m_q), 32'(f[15:0]));
            chk("sym_cnt", 32'(sym_cnt), 32'(xfers % FS));
            chk("m_last", 32'(m_last), 32'((xfers % FS) == FS - 1));
        end else begin
            chk("m_i_idle", 32'(m_i), 32'h0);
            chk("m_q_idle", 32'(m_q), 32'h0);
            chk("m_last_idle", 32'(m_last), 32'h0);
        end
        acc = sv & er;
        mx  = ev & mr;
        @(posedge clk);
        if (mx) begin
            hit[f[35:32]] = 1'b1;
            void'(exp_q.pop_front());
            xfers++;
            if (lst) n_last++;
        end
        if (acc) push_byte(sd);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_i", 32'(m_i), 32'h0);
        chk("rst_m_q", 32'(m_q), 32'h0);
        chk("rst_sym_cnt", 32'(sym_cnt), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        exp_q.delete();
        xfers  = 0;
        n_last = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) step(1'b0, 8'h00, 1'b1, acc);
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        step(1'b0, 8'h00, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   k;
        int   cnt;
        logic [7:0] bytes[32];

        @(posedge clk);
        #1;
        do_reset();

        // Directed byte with continuous ready.
        step(1'b1, 8'h1E, 1'b1, acc);
        chk("t2_acc", 32'(acc), 32'h1);
        drain();

        // Stall in HI for 3 cycles.
        step(1'b1, 8'hB4, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h5A, 1'b0, acc);
        chk("t3_hold_i", 32'(m_i), 32'h0300);
        step(1'b0, 8'h00, 1'b1, acc);
        drain();

        // 32 bytes back to back: one full frame without gaps.
        do_reset();
        for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
        k = 0;
        cnt = 0;
        for (int c = 0; c < 200 && k < 32; c++) begin
            step(1'b1, bytes[k], 1'b1, acc);
            cnt++;
            if (acc) k++;
        end
        chk("t4_sent", 32'(k), 32'd32);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            step(1'b0, 8'h00, 1'b1, acc);
            cnt++;
        end
        chk("t4_gapfree", 32'(cnt), 32'd65);
        chk("t4_last_cnt", 32'(n_last), 32'd1);
        chk("t4_wrap", 32'(sym_cnt), 32'h0);
        step(1'b0, 8'h00, 1'b1, acc);

        // Reset while in LO at sym_cnt 17.
        do_reset();
        for (int c = 0; c < 100 && !(xfers == 17 && exp_q.size() == 1); c++)
            step(1'b1, 8'($urandom), 1'b1, acc);
        chk("t5_at17", 32'(sym_cnt), 32'd17);
        do_reset();
        step(1'b1, 8'h00, 1'b1, acc);
        chk("t5_i", 32'(m_i), 32'hFD00);
        chk("t5_q", 32'(m_q), 32'hFD00);
        chk("t5_cnt", 32'(sym_cnt), 32'h0);
        drain();

        // Random valid/ready over four frames.
        do_reset();
        for (int i = 0; i < 16; i++) hit[i] = 1'b0;
        for (int c = 0; c < 5000 && xfers < 4 * FS; c++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        chk("t6_done", 32'(xfers >= 4 * FS), 32'h1);
        drain();
        chk("t6_last_cnt", 32'(n_last), 32'(xfers / FS));
        cnt = 0;
        for (int i = 0; i < 16; i++) if (hit[i]) cnt++;
        chk("t6_nibble_cov", 32'(cnt), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
